// File: rtl/noc_link_tx.sv
// noc_link_tx: output-side drain engine for one router port.
// Pops flits from a synchronous FIFO and drives them onto a credit-based
// inter-router link. It tracks packet framing so that a tx_en stop only
// takes effect between packets. Credits are reserved when a read is issued.
module noc_link_tx #(
    parameter int DATA_WIDTH = 12,
    parameter int CREDITS    = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_cs,
    output logic                  fifo_rd_en,
    output logic                  link_valid,
    output logic [DATA_WIDTH-1:0] link_data,
    input  logic                  credit_in,
    output logic [CNT_WIDTH-1:0]  credit_cnt,
    output logic                  credit_err,
    output logic                  pkt_err
);

    localparam logic [1:0] TYPE_HEAD   = 2'b10;
    localparam logic [1:0] TYPE_BODY   = 2'b00;
    localparam logic [1:0] TYPE_TAIL   = 2'b01;
    localparam logic [1:0] TYPE_SINGLE = 2'b11;

    localparam logic [CNT_WIDTH-1:0] CREDIT_MAX = CNT_WIDTH'(CREDITS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = CNT_WIDTH'(0);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   cs_r;
    logic                   link_valid_r;
    logic [CNT_WIDTH-1:0]   credit_cnt_r;
    logic [CNT_WIDTH-1:0]   credit_cnt_nxt_s;
    logic                   credit_err_r;
    logic                   credit_err_nxt_s;
    logic                   pkt_err_r;
    logic                   pkt_err_nxt_s;
    logic [1:0]             flit_type_s;
    logic                   pkt_open_s;
    logic                   have_credit_s;
    logic                   rd_en_s;

    // A head or body flit on the link means more of the packet must follow.
    function automatic logic type_keeps_open(input logic [1:0] ftype);
        return (ftype == TYPE_HEAD) || (ftype == TYPE_BODY);
    endfunction

    // Type field of the flit currently presented by the FIFO (valid only with link_valid_r).
    assign flit_type_s = fifo_data[DATA_WIDTH-1 -: 2];

    // Read-issue decision: packet boundary is judged on the flit currently on the link.
    always_comb begin
        pkt_open_s    = 1'b0;
        have_credit_s = 1'b0;
        rd_en_s       = 1'b0;
        if (link_valid_r) begin
            pkt_open_s = type_keeps_open(flit_type_s);
        end else begin
            pkt_open_s = (state_r == IN_PKT);
        end
        // A credit arriving this cycle can fund a read issued this same cycle.
        have_credit_s = (credit_cnt_r != CNT_ZERO) || credit_in;
        rd_en_s       = cs_r && !fifo_empty && have_credit_s && (tx_en || pkt_open_s);
    end

    // Credit accounting: a credit is spent at read issue, returned by credit_in.
    always_comb begin
        credit_cnt_nxt_s = credit_cnt_r;
        credit_err_nxt_s = credit_err_r;
        if (rd_en_s && !credit_in) begin
            credit_cnt_nxt_s = credit_cnt_r - CNT_ONE;
        end else if (!rd_en_s && credit_in) begin
            if (credit_cnt_r == CREDIT_MAX) begin
                credit_err_nxt_s = 1'b1;
            end else begin
                credit_cnt_nxt_s = credit_cnt_r + CNT_ONE;
            end
        end else begin
            credit_cnt_nxt_s = credit_cnt_r;
        end
    end

    // Framing FSM: advanced by the type of each flit leaving on the link.
    always_comb begin
        state_nxt_s   = state_r;
        pkt_err_nxt_s = pkt_err_r;
        if (link_valid_r) begin
            case (flit_type_s)
                TYPE_HEAD: begin
                    if (state_r == IN_PKT) begin
                        pkt_err_nxt_s = 1'b1;
                    end else begin
                        pkt_err_nxt_s = pkt_err_r;
                    end
                    state_nxt_s = IN_PKT;
                end
                TYPE_BODY: begin
                    if (state_r == IDLE) begin
                        pkt_err_nxt_s = 1'b1;
                    end else begin
                        pkt_err_nxt_s = pkt_err_r;
                    end
                end
                TYPE_TAIL: begin
                    if (state_r == IDLE) begin
                        pkt_err_nxt_s = 1'b1;
                    end else begin
                        pkt_err_nxt_s = pkt_err_r;
                    end
                    state_nxt_s = IDLE;
                end
                TYPE_SINGLE: begin
                    if (state_r == IN_PKT) begin
                        pkt_err_nxt_s = 1'b1;
                    end else begin
                        pkt_err_nxt_s = pkt_err_r;
                    end
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s   = state_r;
                    pkt_err_nxt_s = pkt_err_r;
                end
            endcase
        end else begin
            state_nxt_s   = state_r;
            pkt_err_nxt_s = pkt_err_r;
        end
    end

    // State registers; reset drops any in-flight read and open packet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_r         <= 1'b0;
            link_valid_r <= 1'b0;
            credit_cnt_r <= CREDIT_MAX;
            credit_err_r <= 1'b0;
            pkt_err_r    <= 1'b0;
            state_r      <= IDLE;
        end else begin
            cs_r         <= 1'b1;
            link_valid_r <= rd_en_s;
            credit_cnt_r <= credit_cnt_nxt_s;
            credit_err_r <= credit_err_nxt_s;
            pkt_err_r    <= pkt_err_nxt_s;
            state_r      <= state_nxt_s;
        end
    end

    assign fifo_rd_cs = cs_r;
    assign fifo_rd_en = rd_en_s;
    assign link_valid = link_valid_r;
    assign link_data  = link_valid_r ? fifo_data : {DATA_WIDTH{1'b0}};
    assign credit_cnt = credit_cnt_r;
    assign credit_err = credit_err_r;
    assign pkt_err    = pkt_err_r;

endmodule

// File: tb/tb_noc_link_tx.sv
// Directed bench for noc_link_tx: a behavioural FIFO feeds the DUT, and a
// scoreboard queue holds every flit written so the link order can be checked.
module tb_noc_link_tx;

    localparam int DW = 12;

    localparam logic [1:0] T_HEAD   = 2'b10;
    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_TAIL   = 2'b01;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_cs;
    logic          fifo_rd_en;
    logic          link_valid;
    logic [DW-1:0] link_data;
    logic          credit_in;
    logic [3:0]    credit_cnt;
    logic          credit_err;
    logic          pkt_err;

    logic [DW-1:0] fifo_mem [0:255];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic [DW-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    int sent   = 0;
    int s0     = 0;

    noc_link_tx #(.DATA_WIDTH(DW), .CREDITS(8), .CNT_WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_cs (fifo_rd_cs),
        .fifo_rd_en (fifo_rd_en),
        .link_valid (link_valid),
        .link_data  (link_data),
        .credit_in  (credit_in),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err),
        .pkt_err    (pkt_err)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // Synchronous FIFO read port: data appears the cycle after a read.
    always @(posedge clk) begin
        if (fifo_rd_cs && fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_data <= fifo_mem[rd_ptr % 256];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_flit(input logic [1:0] t, input logic [9:0] p);
        fifo_mem[wr_ptr % 256] = {t, p};
        exp_q.push_back({t, p});
        wr_ptr++;
    endtask

    // One clock; at the falling edge compare any link flit with the scoreboard.
    task automatic step();
        logic [DW-1:0] e;
        @(posedge clk);
        @(negedge clk);
        if (link_valid) begin
            sent++;
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("link_data", 32'(link_data), 32'(e));
            end
        end else begin
            check("idle_data", 32'(link_data), 32'd0);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_credit();
        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        tx_en     = 1'b1;
        credit_in = 1'b0;
        #1 rst = 1'b0;
        #10;
        check("rst_link_valid", 32'(link_valid), 32'd0);
        check("rst_link_data", 32'(link_data), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_rd_cs", 32'(fifo_rd_cs), 32'd0);
        check("rst_credit_cnt", 32'(credit_cnt), 32'd8);
        check("rst_credit_err", 32'(credit_err), 32'd0);
        check("rst_pkt_err", 32'(pkt_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("rd_cs_after_rst", 32'(fifo_rd_cs), 32'd1);

        // Basic three-flit packet.
        push_flit(T_HEAD, 10'h011);
        push_flit(T_BODY, 10'h022);
        push_flit(T_TAIL, 10'h033);
        #1;
        check("t1_rd_en_first", 32'(fifo_rd_en), 32'd1);
        s0 = sent;
        steps(3);
        check("t1_sent", 32'(sent - s0), 32'd3);
        step();
        check("t1_link_idle", 32'(link_valid), 32'd0);
        check("t1_credit_cnt", 32'(credit_cnt), 32'd5);
        check("t1_rd_en_empty", 32'(fifo_rd_en), 32'd0);

        // Credit exhaustion with a 10-flit packet.
        for (int i = 0; i < 3; i++) pulse_credit();
        check("t2_credit_refill", 32'(credit_cnt), 32'd8);
        push_flit(T_HEAD, 10'h100);
        for (int i = 0; i < 8; i++) push_flit(T_BODY, 10'(10'h101 + i));
        push_flit(T_TAIL, 10'h1ff);
        s0 = sent;
        steps(12);
        check("t2_sent_8", 32'(sent - s0), 32'd8);
        check("t2_credit_zero", 32'(credit_cnt), 32'd0);
        check("t2_stall_rd_en", 32'(fifo_rd_en), 32'd0);
        check("t2_stall_valid", 32'(link_valid), 32'd0);
        pulse_credit();
        steps(3);
        check("t2_sent_9", 32'(sent - s0), 32'd9);
        check("t2_credit_zero_again", 32'(credit_cnt), 32'd0);
        pulse_credit();
        steps(2);
        check("t2_sent_10", 32'(sent - s0), 32'd10);
        for (int i = 0; i < 8; i++) pulse_credit();
        check("t2_credit_full", 32'(credit_cnt), 32'd8);
        check("t2_credit_err", 32'(credit_err), 32'd0);
        check("t2_pkt_err", 32'(pkt_err), 32'd0);

        // tx_en dropped after the head of a 4-flit packet.
        push_flit(T_HEAD, 10'h201);
        push_flit(T_BODY, 10'h202);
        push_flit(T_BODY, 10'h203);
        push_flit(T_TAIL, 10'h204);
        push_flit(T_HEAD, 10'h211);
        push_flit(T_TAIL, 10'h212);
        step();
        check("t3_head_on_link", 32'(link_valid), 32'd1);
        tx_en = 1'b0;
        s0 = sent;
        steps(6);
        check("t3_rest_of_pkt", 32'(sent - s0), 32'd3);
        check("t3_no_new_head", 32'(fifo_rd_en), 32'd0);
        check("t3_link_idle", 32'(link_valid), 32'd0);
        check("t3_pending", 32'(exp_q.size()), 32'd2);
        tx_en = 1'b1;
        steps(3);
        check("t3_second_pkt", 32'(sent - s0), 32'd5);
        check("t3_credit_cnt", 32'(credit_cnt), 32'd2);
        check("t3_pkt_err", 32'(pkt_err), 32'd0);
        for (int i = 0; i < 6; i++) pulse_credit();
        check("t3_credit_full", 32'(credit_cnt), 32'd8);

        // Credit overflow while idle and full.
        pulse_credit();
        check("t4_credit_hold", 32'(credit_cnt), 32'd8);
        check("t4_credit_err", 32'(credit_err), 32'd1);
        steps(3);
        check("t4_credit_err_sticky", 32'(credit_err), 32'd1);

        // Head followed by head.
        push_flit(T_HEAD, 10'h301);
        push_flit(T_HEAD, 10'h302);
        push_flit(T_TAIL, 10'h303);
        s0 = sent;
        steps(4);
        check("t5_all_sent", 32'(sent - s0), 32'd3);
        check("t5_pkt_err", 32'(pkt_err), 32'd1);
        check("t5_credit_cnt", 32'(credit_cnt), 32'd5);
        rst = 1'b0;
        #1;
        check("t5_rst_pkt_err", 32'(pkt_err), 32'd0);
        check("t5_rst_credit_err", 32'(credit_err), 32'd0);
        check("t5_rst_credit_cnt", 32'(credit_cnt), 32'd8);
        check("t5_rst_rd_cs", 32'(fifo_rd_cs), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        push_flit(T_BODY, 10'h311);
        steps(2);
        check("t5_body_idle_err", 32'(pkt_err), 32'd1);

        // Reset the cycle after a mid-packet read issue.
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
        step();
        check("t6_pkt_err_clear", 32'(pkt_err), 32'd0);
        push_flit(T_HEAD, 10'h401);
        push_flit(T_BODY, 10'h402);
        step();
        check("t6_rd_en_mid", 32'(fifo_rd_en), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t6_valid_drop", 32'(link_valid), 32'd0);
        check("t6_data_zero", 32'(link_data), 32'd0);
        check("t6_credit_cnt", 32'(credit_cnt), 32'd8);
        check("t6_rd_en_rst", 32'(fifo_rd_en), 32'd0);
        check("t6_rd_cs_rst", 32'(fifo_rd_cs), 32'd0);
        check("t6_discarded", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        step();
        push_flit(T_SINGLE, 10'h3aa);
        s0 = sent;
        steps(2);
        check("t6_single_sent", 32'(sent - s0), 32'd1);
        check("t6_pkt_err", 32'(pkt_err), 32'd0);
        check("t6_credit_after", 32'(credit_cnt), 32'd7);
        check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
